// File: rtl/unnamed_pkg.sv
// Shared widths, constants and helpers for the CORDIC rotator.
// Internal x/y are Q3.16 plus sign; residual angle carries 13 fraction bits.
package unnamed_pkg;

  localparam int A_W      = 13;
  localparam int A_FRAC   = 10;
  localparam int IO_W     = 12;
  localparam int IO_FRAC  = 10;
  localparam int OUT_W    = 10;
  localparam int OUT_FRAC = 8;

  localparam int XY_W    = 20;
  localparam int XY_FRAC = 16;
  localparam int Z_W     = 16;
  localparam int Z_FRAC  = 13;
  localparam int K_W     = 18;

  localparam int N_STAGES = 16;
  localparam int LATENCY  = 19;

  localparam int XY_SH  = XY_FRAC - IO_FRAC;
  localparam int XY_EXT = XY_W - IO_W - XY_SH;
  localparam int Z_SH   = Z_FRAC - A_FRAC;
  localparam int RND_SH = XY_FRAC - OUT_FRAC;

  localparam logic signed [A_W-1:0] PI_Q      = 13'sd3217;
  localparam logic signed [A_W-1:0] HALF_PI_Q = 13'sd1608;

  // 0.607253 * 2^16
  localparam logic signed [K_W-1:0] INV_K = 18'sd39797;

  localparam logic signed [XY_W:0] RND_Q =
    (XY_W+1)'(1) << (RND_SH - 1);

  localparam logic signed [OUT_W-1:0] OUT_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN =
    {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic signed [XY_W-1:0] x;
    logic signed [XY_W-1:0] y;
    logic signed [Z_W-1:0]  z;
  } cordic_t;

  // atan(2^-i) scaled by 2^13
  function automatic logic signed [Z_W-1:0] atan_q(
    input int i
  );
    logic signed [Z_W-1:0] v;
    case (i)
      0:       v = 16'sd6434;
      1:       v = 16'sd3798;
      2:       v = 16'sd2007;
      3:       v = 16'sd1019;
      4:       v = 16'sd511;
      5:       v = 16'sd256;
      6:       v = 16'sd128;
      7:       v = 16'sd64;
      8:       v = 16'sd32;
      9:       v = 16'sd16;
      10:      v = 16'sd8;
      11:      v = 16'sd4;
      12:      v = 16'sd2;
      13:      v = 16'sd1;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_round(
    input logic signed [XY_W-1:0] v
  );
    logic signed [XY_W:0]    r;
    logic signed [XY_W:0]    t;
    logic signed [OUT_W-1:0] o;
    r = (XY_W+1)'(v);
    r = r + RND_Q;
    t = r >>> RND_SH;
    if (t[XY_W:OUT_W-1] == {(XY_W-OUT_W+2){t[XY_W]}})
      o = t[OUT_W-1:0];
    else if (t[XY_W])
      o = OUT_MIN;
    else
      o = OUT_MAX;
    return o;
  endfunction

endpackage

// File: rtl/unnamed_if.sv
// Sample bus of the CORDIC rotator: angle and vector in,
// rotated vector out, one sample per clock, no handshake.
interface unnamed_if;
  import unnamed_pkg::*;

  logic signed [A_W-1:0]   a;
  logic signed [IO_W-1:0]  x;
  logic signed [IO_W-1:0]  y;
  logic signed [OUT_W-1:0] xo;
  logic signed [OUT_W-1:0] yo;

  modport master (
    output a,
    output x,
    output y,
    input  xo,
    input  yo
  );

  modport slave (
    input  a,
    input  x,
    input  y,
    output xo,
    output yo
  );

endinterface

// File: rtl/unnamed_stage.sv
// One CORDIC micro-rotation register stage for iteration I.
// Direction follows the residual angle sign (>= 0 rotates positive).
module unnamed_stage
  import unnamed_pkg::*;
#(
  parameter int I = 0
) (
  input  logic    clk,
  input  logic    areset,
  input  cordic_t d_i,
  output cordic_t q_o
);

  logic signed [XY_W-1:0] x;
  logic signed [XY_W-1:0] y;
  logic signed [XY_W-1:0] xs;
  logic signed [XY_W-1:0] ys;
  logic signed [Z_W-1:0]  z;
  cordic_t st_d;
  cordic_t st_q;

  always_comb begin
    x    = d_i.x;
    y    = d_i.y;
    z    = d_i.z;
    xs   = x >>> I;
    ys   = y >>> I;
    st_d = d_i;
    if (!z[Z_W-1]) begin
      st_d.x = x - ys;
      st_d.y = y + xs;
      st_d.z = z - atan_q(I);
    end else begin
      st_d.x = x + ys;
      st_d.y = y - xs;
      st_d.z = z + atan_q(I);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      st_q <= '0;
    else
      st_q <= st_d;
  end

  assign q_o = st_q;

endmodule

// File: rtl/unnamed.sv
// 19-cycle CORDIC rotator; gain compensation in stage 18 is
// enabled by defining UNNAMED_GAIN_COMP_EN.
module unnamed
  import unnamed_pkg::*;
(
  input logic      clk,
  input logic      areset,
  unnamed_if.slave bus
);

  logic signed [A_W-1:0]  a_cl;
  logic signed [A_W-1:0]  a_rot;
  logic signed [XY_W-1:0] x_ext;
  logic signed [XY_W-1:0] y_ext;
  logic                   pre_rot;
  cordic_t                s1_d;
  cordic_t                s1_q;

  // Clamp to +-pi, then fold the outer half-plane by a pi turn
  always_comb begin
    a_cl = bus.a;
    if (bus.a > PI_Q)
      a_cl = PI_Q;
    else if (bus.a < -PI_Q)
      a_cl = -PI_Q;
    pre_rot = 1'b0;
    a_rot   = a_cl;
    if (a_cl > HALF_PI_Q) begin
      pre_rot = 1'b1;
      a_rot   = a_cl - PI_Q;
    end else if (a_cl < -HALF_PI_Q) begin
      pre_rot = 1'b1;
      a_rot   = a_cl + PI_Q;
    end
    x_ext = {{XY_EXT{bus.x[IO_W-1]}},
             bus.x, {XY_SH{1'b0}}};
    y_ext = {{XY_EXT{bus.y[IO_W-1]}},
             bus.y, {XY_SH{1'b0}}};
    s1_d.x = pre_rot ? -x_ext : x_ext;
    s1_d.y = pre_rot ? -y_ext : y_ext;
    s1_d.z = {a_rot, {Z_SH{1'b0}}};
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      s1_q <= '0;
    else
      s1_q <= s1_d;
  end

  cordic_t pipe [0:N_STAGES];

  assign pipe[0] = s1_q;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_rot
    unnamed_stage #(
      .I(g)
    ) u_stage (
      .clk    (clk),
      .areset (areset),
      .d_i    (pipe[g]),
      .q_o    (pipe[g+1])
    );
  end

  logic                   unused_z;
  logic signed [XY_W-1:0] xf;
  logic signed [XY_W-1:0] yf;
  logic signed [XY_W-1:0] gx_d;
  logic signed [XY_W-1:0] gy_d;
  logic signed [XY_W-1:0] gx_q;
  logic signed [XY_W-1:0] gy_q;

  assign unused_z = ^pipe[N_STAGES].z;
  assign xf       = pipe[N_STAGES].x;
  assign yf       = pipe[N_STAGES].y;

`ifdef UNNAMED_GAIN_COMP_EN
  logic signed [XY_W+K_W-1:0] px;
  logic signed [XY_W+K_W-1:0] py;

  always_comb begin
    px   = xf * INV_K;
    py   = yf * INV_K;
    gx_d = XY_W'(px >>> XY_FRAC);
    gy_d = XY_W'(py >>> XY_FRAC);
  end
`else
  assign gx_d = xf;
  assign gy_d = yf;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end

  logic signed [OUT_W-1:0] xo_d;
  logic signed [OUT_W-1:0] yo_d;
  logic signed [OUT_W-1:0] xo_q;
  logic signed [OUT_W-1:0] yo_q;

  assign xo_d = sat_round(gx_q);
  assign yo_d = sat_round(gy_q);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      xo_q <= '0;
      yo_q <= '0;
    end else begin
      xo_q <= xo_d;
      yo_q <= yo_d;
    end
  end

  assign bus.xo = xo_q;
  assign bus.yo = yo_q;

endmodule

// File: tb/tb_unnamed.sv
// Directed bench for the CORDIC rotator; expected values are
// hand-computed for both gain-compensated and raw-gain builds.
module tb_unnamed;

`ifdef UNNAMED_GAIN_COMP_EN
  localparam int E_HALF  = 128;
  localparam int E_QTR   = 64;
  localparam int E_ONE   = -256;
  localparam int E_S2    = 68;
  localparam int E_S6    = 76;
`else
  localparam int E_HALF  = 211;
  localparam int E_QTR   = 105;
  localparam int E_ONE   = -422;
  localparam int E_S2    = 112;
  localparam int E_S6    = 125;
`endif

  logic clk;
  logic areset;
  int   n_pass;
  int   n_total;
  int   n;

  unnamed_if bus ();

  unnamed dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp,
    input int    tol
  );
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_total++;
    assert (d <= tol) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d tol %0d",
                tag, obs, exp, tol);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input logic signed [12:0] av,
    input logic signed [11:0] xv,
    input logic signed [11:0] yv
  );
    bus.a = av;
    bus.x = xv;
    bus.y = yv;
    repeat (19) step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    areset  = 1'b0;
    bus.a   = '0;
    bus.x   = '0;
    bus.y   = '0;
    #2 areset = 1'b1;
    #1;
    chk("reset_xo", int'(bus.xo), 0, 0);
    chk("reset_yo", int'(bus.yo), 0, 0);
    step();
    step();
    areset = 1'b0;

    run(13'sd1608, 12'h200, 12'h000);
    chk("halfpi_xo", int'(bus.xo), 0, 1);
    chk("halfpi_yo", int'(bus.yo), E_HALF, 1);

    run(13'sd0, 12'h100, 12'hE00);
    chk("zero_xo", int'(bus.xo), E_QTR, 1);
    chk("zero_yo", int'(bus.yo), -2 * E_QTR, 2);

    run(13'sd3217, 12'h400, 12'h000);
    chk("pi_xo", int'(bus.xo), E_ONE, 1);
    chk("pi_yo", int'(bus.yo), 0, 1);

    run(13'sd4000, 12'h400, 12'h000);
    chk("clamp_hi_xo", int'(bus.xo), E_ONE, 1);
    chk("clamp_hi_yo", int'(bus.yo), 0, 1);

    run(-13'sd4000, 12'h400, 12'h000);
    chk("clamp_lo_xo", int'(bus.xo), E_ONE, 1);
    chk("clamp_lo_yo", int'(bus.yo), 0, 1);

    run(13'sd804, 12'h7FF, 12'h7FF);
    chk("satp_xo", int'(bus.xo), 0, 1);
    chk("satp_yo", int'(bus.yo), 511, 0);

    run(13'sd804, 12'h801, 12'h801);
    chk("satn_xo", int'(bus.xo), 0, 1);
    chk("satn_yo", int'(bus.yo), -512, 0);

    run(13'sd0, 12'h200, 12'h000);
    chk("gain_xo", int'(bus.xo), E_HALF, 1);
    chk("gain_yo", int'(bus.yo), 0, 1);

    run(-13'sd1608, 12'h200, 12'h000);
    chk("neghalf_xo", int'(bus.xo), 0, 1);
    chk("neghalf_yo", int'(bus.yo), -E_HALF, 1);

    for (int k = 0; k < 25; k++) begin
      bus.a = '0;
      bus.y = '0;
      bus.x = 12'(12'h100 + 8 * k);
      step();
      if (k == 20)
        chk("stream_s2_xo", int'(bus.xo), E_S2, 1);
      if (k == 24)
        chk("stream_s6_xo", int'(bus.xo), E_S6, 1);
    end

    areset = 1'b1;
    #1;
    chk("midrst_xo", int'(bus.xo), 0, 0);
    chk("midrst_yo", int'(bus.yo), 0, 0);
    for (int k = 25; k < 40; k++) begin
      bus.x = 12'(12'h100 + 8 * k);
      step();
    end
    areset = 1'b0;
    bus.x  = '0;
    repeat (3) step();

    bus.a = '0;
    bus.y = '0;
    bus.x = 12'h200;
    n = 0;
    do begin
      step();
      n++;
      bus.x = '0;
    end while (bus.xo == '0 && n < 40);
    chk("post_rst_latency", n, 19, 0);
    chk("post_rst_xo", int'(bus.xo), E_HALF, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
